// File: rtl/gate_bank_reg.sv
// gate_bank_reg: registered bank of basic gates (WIDTH-bit AND, 1-bit OR,
// 1-bit NAND), a registered valid flag and a saturating counter of
// captures whose AND result is nonzero.
// Optional feature: define GATE_PARITY_EN to add the and_par output, the
// registered XOR-reduce of (and_a & and_b).
module gate_bank_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] and_a,
  input  logic [WIDTH-1:0] and_b,
  input  logic             or_a,
  input  logic             or_b,
  input  logic             nand_a,
  input  logic             nand_b,
  output logic [WIDTH-1:0] and_y,
  output logic             or_y,
  output logic             nand_y,
  output logic             out_valid,
  output logic [CNT_W-1:0] and_nz_cnt
`ifdef GATE_PARITY_EN
  ,
  output logic             and_par
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] and_y_q, and_y_d;
  logic             or_y_q, or_y_d;
  logic             nand_y_q, nand_y_d;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign and_res = and_a & and_b;

  // Next-state: load the gate functions on capture, otherwise hold;
  // the counter advances on nonzero AND captures and sticks at its maximum.
  always_comb begin
    and_y_d  = and_y_q;
    or_y_d   = or_y_q;
    nand_y_d = nand_y_q;
    cnt_d    = cnt_q;
    if (in_valid) begin
      and_y_d  = and_res;
      or_y_d   = or_a | or_b;
      nand_y_d = ~(nand_a & nand_b);
      if ((|and_res) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      and_y_q  <= '0;
      or_y_q   <= 1'b0;
      nand_y_q <= 1'b1;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      and_y_q  <= and_y_d;
      or_y_q   <= or_y_d;
      nand_y_q <= nand_y_d;
      valid_q  <= in_valid;
      cnt_q    <= cnt_d;
    end
  end

  assign and_y      = and_y_q;
  assign or_y       = or_y_q;
  assign nand_y     = nand_y_q;
  assign out_valid  = valid_q;
  assign and_nz_cnt = cnt_q;

`ifdef GATE_PARITY_EN
  logic par_q, par_d;

  // Parity of the AND result follows and_y: capture, hold, reset to 0.
  always_comb begin
    par_d = par_q;
    if (in_valid) begin
      par_d = ^and_res;
    end
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign and_par = par_q;
`endif

endmodule

// File: tb/tb_gate_bank_reg.sv
// tb_gate_bank_reg: randomized and directed stimulus with a scoreboard.
// The driver computes the expected outputs after each edge from the gate
// rules and queues them; a monitor pops one entry per edge and compares.
module tb_gate_bank_reg;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] and_a = '0, and_b = '0;
  logic             or_a = 1'b0, or_b = 1'b0, nand_a = 1'b0, nand_b = 1'b0;
  logic [WIDTH-1:0] and_y;
  logic             or_y, nand_y, out_valid;
  logic [CNT_W-1:0] and_nz_cnt;
  logic             par_act;

  always #5 clk = ~clk;

  gate_bank_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .and_a(and_a), .and_b(and_b), .or_a(or_a), .or_b(or_b),
    .nand_a(nand_a), .nand_b(nand_b),
    .and_y(and_y), .or_y(or_y), .nand_y(nand_y),
    .out_valid(out_valid), .and_nz_cnt(and_nz_cnt)
`ifdef GATE_PARITY_EN
    , .and_par(par_act)
`endif
  );

`ifndef GATE_PARITY_EN
  assign par_act = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] and_y;
    logic             or_y;
    logic             nand_y;
    logic             valid;
    int               cnt;
    logic             par;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;

  // Reference state: what the outputs should be after the last edge.
  exp_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s txn=%0d got=%0h expected=%0h", name, n_txn, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic oa, input logic ob,
                       input logic na, input logic nb);
    @(negedge clk);
    rst_n = r; in_valid = v; and_a = a; and_b = b;
    or_a = oa; or_b = ob; nand_a = na; nand_b = nb;
    if (!r) begin
      m.and_y = '0; m.or_y = 1'b0; m.nand_y = 1'b1;
      m.valid = 1'b0; m.cnt = 0; m.par = 1'b0;
    end else begin
      m.valid = v;
      if (v) begin
        m.and_y  = a & b;
        m.or_y   = oa | ob;
        m.nand_y = !(na && nb);
        m.par    = ^(a & b);
        if ((a & b) != 0) m.cnt = (m.cnt + 1 > CNT_MAX) ? CNT_MAX : m.cnt + 1;
      end
    end
    q.push_back(m);
  endtask

  // Monitor: after each edge compare the DUT against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_txn++;
        check("out_valid", 32'(out_valid), 32'(e.valid));
        check("and_y", 32'(and_y), 32'(e.and_y));
        check("or_y", 32'(or_y), 32'(e.or_y));
        check("nand_y", 32'(nand_y), 32'(e.nand_y));
        check("and_nz_cnt", 32'(and_nz_cnt), e.cnt);
`ifdef GATE_PARITY_EN
        check("and_par", 32'(par_act), 32'(e.par));
`endif
        $display("txn %0d: valid=%0b and_y=%b or_y=%0b nand_y=%0b cnt=%0d",
                 n_txn, out_valid, and_y, or_y, nand_y, and_nz_cnt);
      end else if (out_valid === 1'b1) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  // Stimulus: spec scenarios followed by randomized traffic.
  initial begin
    m = '{and_y: '0, or_y: 1'b0, nand_y: 1'b1, valid: 1'b0, cnt: 0, par: 1'b0};
    // Reset for two edges.
    drive(0, 0, '0, '0, 0, 0, 0, 0);
    drive(0, 0, '0, '0, 0, 0, 0, 0);
    // Disjoint AND operands give zero and no count.
    drive(1, 1, 4'b1010, 4'b0101, 0, 0, 0, 0);
    drive(1, 1, 4'b0101, 4'b1010, 0, 0, 0, 0);
    // OR / NAND truth-table walk.
    drive(1, 1, '0, '0, 1, 1, 1, 1);
    drive(1, 1, '0, '0, 1, 0, 1, 0);
    drive(1, 1, '0, '0, 1, 1, 1, 1);
    drive(1, 1, '0, '0, 0, 0, 0, 0);
    // Saturation: 300 nonzero captures.
    for (int i = 0; i < 300; i++) drive(1, 1, 4'b1111, 4'b0110, 0, 0, 0, 0);
    // Hold while inputs change.
    for (int i = 0; i < 4; i++)
      drive(1, 0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
    // Reset overrides a simultaneous capture.
    drive(0, 1, 4'b1111, 4'b1111, 1, 1, 1, 1);
    drive(1, 0, 4'b1111, 4'b1111, 1, 1, 1, 1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 39) != 0), 1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1, 0, '0, '0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
